scalar_wb_unit: RTL

// - Writeback/completion end of the scoreboard: consumes finished wb_t results from FUs, arbitrates one per cycle.
// - Drives the scalar RF write port and the matrix-reg release.
// - Broadcasts completing FU id so FUST t1/t2 dependency tags and RST busy/tag entries clear.
// - Sits between the FU outputs (ALU, scalar LD_ST, matrix LD_ST) and the RF/FUST/RST.

---
 rtl/datapath_pkg.sv | 35 +++
 rtl/scalar_wb_unit_arbiter.sv | 39 +++
 rtl/scalar_wb_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types for the scoreboard writeback path: result payloads,
// register/FU index widths and the completion broadcast record.
package datapath_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_W      = 5;
    localparam int MAT_W      = 3;
    localparam int FU_W       = 2;
    localparam int NUM_WB_SRC = 3;

    typedef logic [REG_W-1:0] regbits_t;
    typedef logic [MAT_W-1:0] matbits_t;
    typedef logic [FU_W-1:0]  fu_sbits_t;

    // Source index doubles as the FU id used in FUST/RST tag compares.
    typedef enum logic [FU_W-1:0] {
        WB_SRC_ALU   = 2'd0,
        WB_SRC_SLDST = 2'd1,
        WB_SRC_MLDST = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic              s_rw_en;
        regbits_t          s_rw;
        logic              m_rw_en;
        matbits_t          m_rw;
        logic [WORD_W-1:0] s_wdata;
    } wb_t;

    typedef struct packed {
        logic      valid;
        fu_sbits_t fu;
    } wb_done_t;

endpackage

// File: rtl/scalar_wb_unit_arbiter.sv
// Round-robin arbiter over holding-buffer requests; the search begins at
// rr_ptr and wraps, producing a one-hot grant plus its index.
module wb_rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int               idx_i;
    logic [IDX_W-1:0] idx;

    // Walk from farthest to nearest offset so the entry closest to rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx_i     = 0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_i = int'(rr_ptr) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end
            idx = IDX_W'(idx_i);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scalar_wb_unit.sv
// Writeback/completion stage: buffers one result per FU, picks one per cycle
// round-robin, drives the RF write port, matrix release and FU-done broadcast.
module scalar_wb_unit
    import datapath_pkg::*;
#(
    parameter int NUM_WB_SRC = datapath_pkg::NUM_WB_SRC,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_WB_SRC-1:0] src_valid,
    input  wb_t                   src_wb [NUM_WB_SRC],
    output logic [NUM_WB_SRC-1:0] src_ready,
    output logic                  rf_wen,
    output regbits_t              rf_waddr,
    output logic [WORD_W-1:0]     rf_wdata,
    output logic                  mrf_rel_en,
    output matbits_t              mrf_rel_idx,
    output logic                  done_valid,
    output fu_sbits_t             done_fu,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int IDX_W = (NUM_WB_SRC > 1) ? $clog2(NUM_WB_SRC) : 1;

    logic [NUM_WB_SRC-1:0] buf_vld_q, buf_vld_d;
    wb_t                   buf_wb_q [NUM_WB_SRC];
    wb_t                   buf_wb_d [NUM_WB_SRC];
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_WB_SRC-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    wb_t                   gnt_wb;

    logic                  rf_wen_q, rf_wen_d;
    regbits_t              rf_waddr_q, rf_waddr_d;
    logic [WORD_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic                  mrf_rel_en_q, mrf_rel_en_d;
    matbits_t              mrf_rel_idx_q, mrf_rel_idx_d;
    wb_done_t              done_q, done_d;
    logic [CNT_W-1:0]      conflict_cnt_q, conflict_cnt_d;
    int unsigned           pending;

    wb_rr_arbiter #(
        .N     (NUM_WB_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (buf_vld_q),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // A granted buffer drains this cycle, so it may refill at the same edge.
    always_comb begin
        src_ready = ~buf_vld_q | grant;
        pending   = 0;
        for (int i = 0; i < NUM_WB_SRC; i++) begin
            buf_vld_d[i] = buf_vld_q[i];
            buf_wb_d[i]  = buf_wb_q[i];
            if (buf_vld_q[i]) begin
                pending = pending + 1;
            end
            if (src_valid[i] && src_ready[i]) begin
                buf_vld_d[i] = 1'b1;
                buf_wb_d[i]  = src_wb[i];
            end else if (grant[i]) begin
                buf_vld_d[i] = 1'b0;
            end
        end
        conflict_cnt_d = conflict_cnt_q;
        if (pending >= 2 && conflict_cnt_q != '1) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    // Index/data/FU outputs hold across idle cycles; only the strobes drop.
    always_comb begin
        gnt_wb        = buf_wb_q[grant_idx];
        rf_wen_d      = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        mrf_rel_en_d  = 1'b0;
        mrf_rel_idx_d = mrf_rel_idx_q;
        done_d.valid  = 1'b0;
        done_d.fu     = done_q.fu;
        rr_ptr_d      = rr_ptr_q;
        if (grant_any) begin
            rf_wen_d      = gnt_wb.s_rw_en && (gnt_wb.s_rw != '0);
            rf_waddr_d    = gnt_wb.s_rw;
            rf_wdata_d    = gnt_wb.s_wdata;
            mrf_rel_en_d  = gnt_wb.m_rw_en;
            mrf_rel_idx_d = gnt_wb.m_rw;
            done_d.valid  = 1'b1;
            done_d.fu     = fu_sbits_t'(grant_idx);
            rr_ptr_d      = (grant_idx == IDX_W'(NUM_WB_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_vld_q      <= '0;
            rr_ptr_q       <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            mrf_rel_en_q   <= 1'b0;
            mrf_rel_idx_q  <= '0;
            done_q         <= '0;
            conflict_cnt_q <= '0;
            for (int i = 0; i < NUM_WB_SRC; i++) begin
                buf_wb_q[i] <= '0;
            end
        end else begin
            buf_vld_q      <= buf_vld_d;
            rr_ptr_q       <= rr_ptr_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            mrf_rel_en_q   <= mrf_rel_en_d;
            mrf_rel_idx_q  <= mrf_rel_idx_d;
            done_q         <= done_d;
            conflict_cnt_q <= conflict_cnt_d;
            for (int i = 0; i < NUM_WB_SRC; i++) begin
                buf_wb_q[i] <= buf_wb_d[i];
            end
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign mrf_rel_en   = mrf_rel_en_q;
    assign mrf_rel_idx  = mrf_rel_idx_q;
    assign done_valid   = done_q.valid;
    assign done_fu      = done_q.fu;
    assign conflict_cnt = conflict_cnt_q;

endmodule
